// File: rtl/rf_seq_pkg.sv
// Shared constants, opcode encoding and FSM state type for the register-file op sequencer.
package rf_seq_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_AND = 4'd2;
  localparam op_t OP_OR  = 4'd3;
  localparam op_t OP_XOR = 4'd4;
  localparam op_t OP_SLT = 4'd5;
  localparam op_t OP_SLL = 4'd6;
  localparam op_t OP_SRL = 4'd7;
  localparam op_t OP_LDI = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StExec,
    StWrite
  } state_e;

  function automatic logic is_legal_op(op_t op);
    return op <= OP_LDI;
  endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Command/response handshake between the decode stage (master) and the sequencer (slave).
interface rf_op_sequencer_if
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic [ADDR_W-1:0] cmd_rs;
  logic [ADDR_W-1:0] cmd_rt;
  logic [ADDR_W-1:0] cmd_rd;
  logic [DATA_W-1:0] cmd_imm;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_result;
  logic              resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
    input  cmd_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
    output cmd_ready, resp_valid, resp_result, resp_err
  );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational result unit: evaluates one register-register opcode and flags illegal ones.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(DATA_W - 1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Issues one command at a time to a 2R/1W register file: read, compute, write back, respond.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter bit          R0_PROTECT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  rf_op_sequencer_if.slave  cmd,
  output logic [ADDR_W-1:0] regno1,
  output logic [ADDR_W-1:0] regno2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              write
);

  state_e            state;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic              illegal_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  rf_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op      (op_q),
    .a       (rdata1),
    .b       (rdata2),
    .imm     (imm_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign cmd.cmd_ready = (state == StIdle) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      op_q            <= OP_ADD;
      rd_q            <= '0;
      imm_q           <= '0;
      illegal_q       <= 1'b0;
      regno1          <= '0;
      regno2          <= '0;
      wreg            <= '0;
      wdata           <= '0;
      write           <= 1'b0;
      cmd.resp_valid  <= 1'b0;
      cmd.resp_result <= '0;
      cmd.resp_err    <= 1'b0;
    end else begin
      cmd.resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            rd_q   <= cmd.cmd_rd;
            imm_q  <= cmd.cmd_imm;
            regno1 <= cmd.cmd_rs;
            regno2 <= cmd.cmd_rt;
            state  <= StIssue;
          end
        end
        // The file captures read data on this edge; nothing to do but wait.
        StIssue: state <= StExec;
        StExec: begin
          wreg      <= rd_q;
          wdata     <= alu_result;
          write     <= !alu_illegal && !(R0_PROTECT && (rd_q == '0));
          illegal_q <= alu_illegal;
          state     <= StWrite;
        end
        StWrite: begin
          write           <= 1'b0;
          cmd.resp_valid  <= 1'b1;
          cmd.resp_result <= wdata;
          cmd.resp_err    <= illegal_q;
          state           <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
